// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared tap table, draw FSM states and width limits for the LFSR random source
package lfsr_pkg;

    localparam int LFSR_MIN_W = 3;
    localparam int LFSR_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        HOLD
    } draw_state_t;

    // Maximal-length XNOR taps, zero-based bit positions, for a left-shifting register.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int width);
        case (width)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - XNOR-feedback shift register with seed load and all-ones lock-up guard
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             res,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] lfsr
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic feedback;

    // XNOR feedback makes all-ones the stuck state, so all-zeros is a legal start.
    assign feedback = ~(^(lfsr & TAPS));

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr <= '0;
        end else if (res) begin
            lfsr <= '0;
        end else if (load) begin
            lfsr <= (seed == '1) ? '0 : seed;
        end else if (en) begin
            lfsr <= {lfsr[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/lfsr_rand_gen.sv
// rtl/lfsr_rand_gen.sv - LFSR random source with a bounded draw port using rejection sampling
module lfsr_rand_gen
    import lfsr_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int MAX_TRIES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             res,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] lfsr,
    input  logic             req,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid,
    output logic             err,
    input  logic             ack
);

    localparam int TRY_W = $clog2(MAX_TRIES) + 1;
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_width
        $error("lfsr_rand_gen: WIDTH %0d outside supported range", WIDTH);
    end

    draw_state_t      state, state_nxt;
    logic [WIDTH-1:0] lim_q, lim_nxt;
    logic [WIDTH-1:0] rnd_nxt;
    logic [TRY_W-1:0] tries, tries_nxt;
    logic             valid_nxt, err_nxt;

    lfsr_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .res   (res),
        .en    (en),
        .load  (load),
        .seed  (seed),
        .lfsr  (lfsr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            lim_q     <= '0;
            tries     <= '0;
            rnd       <= '0;
            rnd_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            lim_q     <= lim_nxt;
            tries     <= tries_nxt;
            rnd       <= rnd_nxt;
            rnd_valid <= valid_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lim_nxt   = lim_q;
        tries_nxt = tries;
        rnd_nxt   = rnd;
        valid_nxt = rnd_valid;
        err_nxt   = err;

        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (req) begin
                    lim_nxt   = limit;
                    tries_nxt = '0;
                    state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                // Each cycle sees a fresh LFSR state only while en is high.
                if (lim_q == '0) begin
                    rnd_nxt   = '0;
                    err_nxt   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end else if (lfsr < lim_q) begin
                    rnd_nxt   = lfsr;
                    err_nxt   = 1'b0;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end else if (tries == TRY_LAST) begin
                    rnd_nxt   = '0;
                    err_nxt   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    tries_nxt = tries + TRY_W'(1);
                end
            end
            HOLD: begin
                if (ack) begin
                    valid_nxt = 1'b0;
                    err_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Restart abandons any draw but leaves the last rnd visible.
        if (res) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            err_nxt   = 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// tb/tb_lfsr_rand_gen.sv - self-checking bench for lfsr_rand_gen at WIDTH 10 and WIDTH 4
module tb_lfsr_rand_gen;

    typedef struct {
        string      name;
        logic       en;
        logic       load;
        logic [9:0] seed;
        logic [9:0] exp_lfsr;
    } vec_t;

    typedef struct {
        logic [9:0] rnd;
        logic       err;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, res, en, load, req, ack;
    logic [9:0] seed, limit, lfsr, rnd;
    logic       rnd_valid, err;

    logic       reset4, en4, req4, ack4, res4, load4;
    logic [3:0] seed4, limit4, lfsr4, rnd4;
    logic       valid4, err4;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [9:0] mdl = '0;
    vec_t       tbl[$];
    exp_t       sb[$];

    always #5 clk = ~clk;

    lfsr_rand_gen #(.WIDTH(10), .MAX_TRIES(64)) u_dut (
        .clk(clk), .reset(reset), .res(res), .en(en), .load(load), .seed(seed),
        .lfsr(lfsr), .req(req), .limit(limit), .rnd(rnd), .rnd_valid(rnd_valid),
        .err(err), .ack(ack)
    );

    lfsr_rand_gen #(.WIDTH(4), .MAX_TRIES(64)) u_dut4 (
        .clk(clk), .reset(reset4), .res(res4), .en(en4), .load(load4), .seed(seed4),
        .lfsr(lfsr4), .req(req4), .limit(limit4), .rnd(rnd4), .rnd_valid(valid4),
        .err(err4), .ack(ack4)
    );

    function automatic logic [9:0] nxt10(input logic [9:0] x);
        return {x[8:0], ~(x[9] ^ x[6])};
    endfunction

    function automatic exp_t predict(input logic [9:0] l0, input logic [9:0] lim, input logic step);
        exp_t e;
        logic [9:0] s;
        s     = l0;
        e.rnd = '0;
        e.err = 1'b1;
        e.lat = 64;
        if (lim == 10'd0) begin
            e.lat = 1;
            return e;
        end
        for (int i = 1; i <= 64; i++) begin
            if (step) s = nxt10(s);
            if (s < lim) begin
                e.rnd = s;
                e.err = 1'b0;
                e.lat = i;
                return e;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset || res) mdl = '0;
        else if (load) mdl = (seed == 10'h3FF) ? 10'h000 : seed;
        else if (en) mdl = nxt10(mdl);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic draw(input logic [9:0] lim, input int hold_cycles);
        exp_t e;
        int   lat;
        req   = 1'b1;
        limit = lim;
        sb.push_back(predict(mdl, lim, en));
        tick();
        req = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!rnd_valid && lat < 100);
        e = sb.pop_front();
        check("draw_latency", lat, e.lat);
        check("draw_rnd", rnd, e.rnd);
        check("draw_err", err, e.err);
        for (int i = 0; i < hold_cycles; i++) begin
            req   = 1'b1;
            limit = 10'h3FF;
            tick();
            check("hold_valid", rnd_valid, 1);
            check("hold_rnd", rnd, e.rnd);
        end
        ack   = 1'b1;
        req   = 1'b1;
        limit = 10'h3FF;
        tick();
        ack = 1'b0;
        req = 1'b0;
        check("ack_clears_valid", rnd_valid, 0);
        check("ack_clears_err", err, 0);
        tick();
        check("no_accept_at_hold_exit", rnd_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   ones, first, w, cnt_f, ret;

        reset = 1'b0; res = 1'b0; en = 1'b0; load = 1'b0; seed = '0;
        req = 1'b0; ack = 1'b0; limit = '0;
        reset4 = 1'b0; res4 = 1'b0; en4 = 1'b0; load4 = 1'b0; seed4 = '0;
        req4 = 1'b0; ack4 = 1'b0; limit4 = '0;

        tbl.push_back('{"step1",    1'b1, 1'b0, 10'h000, 10'd1});
        tbl.push_back('{"step2",    1'b1, 1'b0, 10'h000, 10'd3});
        tbl.push_back('{"step3",    1'b1, 1'b0, 10'h000, 10'd7});
        tbl.push_back('{"step4",    1'b1, 1'b0, 10'h000, 10'd15});
        tbl.push_back('{"step5",    1'b1, 1'b0, 10'h000, 10'd31});
        tbl.push_back('{"step6",    1'b1, 1'b0, 10'h000, 10'd63});
        tbl.push_back('{"step7",    1'b1, 1'b0, 10'h000, 10'd127});
        tbl.push_back('{"step8",    1'b1, 1'b0, 10'h000, 10'd254});
        tbl.push_back('{"step9",    1'b1, 1'b0, 10'h000, 10'd508});
        tbl.push_back('{"step10",   1'b1, 1'b0, 10'h000, 10'd1016});
        tbl.push_back('{"hold_en0", 1'b0, 1'b0, 10'h000, 10'd1016});
        tbl.push_back('{"hold_en0b",1'b0, 1'b0, 10'h2AA, 10'd1016});
        tbl.push_back('{"load_ones",1'b0, 1'b1, 10'h3FF, 10'h000});
        tbl.push_back('{"load_wins",1'b1, 1'b1, 10'h155, 10'h155});
        tbl.push_back('{"step_155", 1'b1, 1'b0, 10'h000, 10'h2AA});
        tbl.push_back('{"load_3fe", 1'b0, 1'b1, 10'h3FE, 10'h3FE});
        tbl.push_back('{"step_3fe", 1'b1, 1'b0, 10'h000, 10'h3FD});

        tick();
        check("reset_lfsr", lfsr, 0);
        check("reset_rnd", rnd, 0);
        check("reset_valid", rnd_valid, 0);
        check("reset_err", err, 0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            en   = tbl[i].en;
            load = tbl[i].load;
            seed = tbl[i].seed;
            tick();
            check(tbl[i].name, lfsr, tbl[i].exp_lfsr);
        end
        en = 1'b0; load = 1'b0;

        do_reset();
        en    = 1'b1;
        ones  = 0;
        first = 0;
        for (int i = 1; i <= 1023; i++) begin
            tick();
            if (lfsr == 10'h3FF) ones++;
            if (lfsr == 10'h000 && first == 0) first = i;
        end
        check("w10_all_ones_seen", ones, 0);
        check("w10_period", first, 1023);

        do_reset();
        en = 1'b1;
        draw(10'd4, 5);
        draw(10'd0, 0);
        for (int k = 0; k < 6; k++) draw(10'($urandom_range(1, 1023)), 1);
        draw(10'h3FF, 0);

        en = 1'b0; load = 1'b1; seed = 10'd5;
        tick();
        load = 1'b0;
        check("seed5_loaded", lfsr, 5);
        draw(10'd1, 0);

        req = 1'b1; limit = 10'd1;
        tick();
        req = 1'b0;
        repeat (3) tick();
        check("searching_no_valid", rnd_valid, 0);
        res = 1'b1;
        tick();
        res = 1'b0;
        check("res_lfsr", lfsr, 0);
        check("res_valid", rnd_valid, 0);
        check("res_err", err, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("res_idle_no_valid", rnd_valid, 0);
        end

        en = 1'b1;
        sb.push_back(predict(mdl, 10'h3FF, 1'b1));
        req = 1'b1; limit = 10'h3FF;
        tick();
        req = 1'b0;
        tick();
        e = sb.pop_front();
        check("pre_reset_valid", rnd_valid, 1);
        check("pre_reset_rnd", rnd, e.rnd);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        en    = 1'b0;
        check("hold_reset_lfsr", lfsr, 0);
        check("hold_reset_rnd", rnd, 0);
        check("hold_reset_valid", rnd_valid, 0);
        check("hold_reset_err", err, 0);

        tick();
        reset4 = 1'b1;
        en4    = 1'b1;
        cnt_f  = 0;
        ret    = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (lfsr4 == 4'hF) cnt_f++;
            if (lfsr4 == 4'h0 && ret == 0) ret = i;
        end
        check("w4_all_ones_seen", cnt_f, 0);
        check("w4_period", ret, 15);

        limit4 = 4'd8;
        for (int k = 0; k < 100; k++) begin
            req4 = 1'b1;
            tick();
            req4 = 1'b0;
            w = 0;
            do begin
                tick();
                w++;
            end while (!valid4 && w < 70);
            check("w4_draw_valid", valid4, 1);
            check("w4_rnd_below_8", (rnd4 < 4'd8), 1);
            check("w4_err", err4, 0);
            ack4 = 1'b1;
            tick();
            ack4 = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
